// File: rtl/ra_64x72_rd_sched.sv
// rtl/ra_64x72_rd_sched.sv - 2R1W port scheduler and zero-fill initializer for the 64x72 register-file array
// Optional RA_WR_BYPASS_EN: a read granted with a same-address write returns the new write data.
module ra_64x72_rd_sched #(
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_vld,
  input  logic [23:0]  req_adr,
  output logic [3:0]   req_gnt,
  input  logic         wr_req,
  input  logic [5:0]   wr_adr,
  input  logic [71:0]  wr_dat,
  output logic         wr_gnt,
  output logic         init_done,
  output logic         rsp_vld_0,
  output logic [1:0]   rsp_id_0,
  output logic [71:0]  rsp_dat_0,
  output logic         rsp_vld_1,
  output logic [1:0]   rsp_id_1,
  output logic [71:0]  rsp_dat_1,
  output logic         rd_enb_0,
  output logic [5:0]   rd_adr_0,
  input  logic [71:0]  rd_dat_0,
  output logic         rd_enb_1,
  output logic [5:0]   rd_adr_1,
  input  logic [71:0]  rd_dat_1,
  output logic         wr_enb_0,
  output logic [5:0]   wr_adr_0,
  output logic [71:0]  wr_dat_0
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic        r_init_done;

  logic        w_hit0, w_hit1;
  logic [1:0]  w_id0, w_id1;

  logic [RD_LAT-1:0] r_vld0, r_vld1;
  logic [1:0]        r_id0 [RD_LAT];
  logic [1:0]        r_id1 [RD_LAT];

  function automatic logic [5:0] adr_sel(input logic [23:0] adrs, input logic [1:0] id);
    case (id)
      2'd0:    adr_sel = adrs[5:0];
      2'd1:    adr_sel = adrs[11:6];
      2'd2:    adr_sel = adrs[17:12];
      default: adr_sel = adrs[23:18];
    endcase
  endfunction

  // Round-robin scan from r_rr_ptr: first hit goes to port 0, second to port 1.
  always_comb begin
    logic [1:0] v_idx;
    w_hit0 = 1'b0;
    w_hit1 = 1'b0;
    w_id0  = 2'd0;
    w_id1  = 2'd0;
    v_idx  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_rr_ptr + 2'(k);
      if (req_vld[v_idx]) begin
        if (!w_hit0) begin
          w_hit0 = 1'b1;
          w_id0  = v_idx;
        end else if (!w_hit1) begin
          w_hit1 = 1'b1;
          w_id1  = v_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rr_ptr_nxt = r_rr_ptr;
    req_gnt      = 4'd0;
    wr_gnt       = 1'b0;
    rd_enb_0     = 1'b0;
    rd_adr_0     = 6'd0;
    rd_enb_1     = 1'b0;
    rd_adr_1     = 6'd0;
    wr_enb_0     = 1'b0;
    wr_adr_0     = 6'd0;
    wr_dat_0     = 72'd0;
    case (r_state)
      ST_INIT: begin
        wr_enb_0  = !reset;
        wr_adr_0  = r_cnt;
        w_cnt_nxt = r_cnt + 6'd1;
        if (r_cnt == 6'd63) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!reset) begin
          wr_gnt   = wr_req;
          wr_enb_0 = wr_req;
          wr_adr_0 = wr_adr;
          wr_dat_0 = wr_dat;
          if (w_hit0) begin
            req_gnt[w_id0] = 1'b1;
            rd_enb_0       = 1'b1;
            rd_adr_0       = adr_sel(req_adr, w_id0);
            w_rr_ptr_nxt   = w_id0 + 2'd1;
          end
          if (w_hit1) begin
            req_gnt[w_id1] = 1'b1;
            rd_enb_1       = 1'b1;
            rd_adr_1       = adr_sel(req_adr, w_id1);
            w_rr_ptr_nxt   = w_id1 + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_cnt       <= 6'd0;
      r_rr_ptr    <= 2'd0;
      r_init_done <= 1'b0;
      r_vld0      <= '0;
      r_vld1      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      r_vld0[0]   <= rd_enb_0;
      r_vld1[0]   <= rd_enb_1;
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld0[s] <= r_vld0[s-1];
        r_vld1[s] <= r_vld1[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_id0[0] <= w_id0;
    r_id1[0] <= w_id1;
    for (int s = 1; s < RD_LAT; s++) begin
      r_id0[s] <= r_id0[s-1];
      r_id1[s] <= r_id1[s-1];
    end
  end

  assign init_done = r_init_done;
  assign rsp_vld_0 = r_vld0[RD_LAT-1] && !reset;
  assign rsp_vld_1 = r_vld1[RD_LAT-1] && !reset;
  assign rsp_id_0  = r_id0[RD_LAT-1];
  assign rsp_id_1  = r_id1[RD_LAT-1];

`ifdef RA_WR_BYPASS_EN
  logic              w_byp0, w_byp1;
  logic [RD_LAT-1:0] r_byp0, r_byp1;
  logic [71:0]       r_bdat0 [RD_LAT];
  logic [71:0]       r_bdat1 [RD_LAT];

  assign w_byp0 = rd_enb_0 && wr_enb_0 && (wr_adr_0 == rd_adr_0);
  assign w_byp1 = rd_enb_1 && wr_enb_0 && (wr_adr_0 == rd_adr_1);

  always_ff @(posedge clk) begin
    r_byp0[0]  <= w_byp0;
    r_byp1[0]  <= w_byp1;
    r_bdat0[0] <= wr_dat_0;
    r_bdat1[0] <= wr_dat_0;
    for (int s = 1; s < RD_LAT; s++) begin
      r_byp0[s]  <= r_byp0[s-1];
      r_byp1[s]  <= r_byp1[s-1];
      r_bdat0[s] <= r_bdat0[s-1];
      r_bdat1[s] <= r_bdat1[s-1];
    end
  end

  assign rsp_dat_0 = !rsp_vld_0 ? 72'd0 : (r_byp0[RD_LAT-1] ? r_bdat0[RD_LAT-1] : rd_dat_0);
  assign rsp_dat_1 = !rsp_vld_1 ? 72'd0 : (r_byp1[RD_LAT-1] ? r_bdat1[RD_LAT-1] : rd_dat_1);
`else
  assign rsp_dat_0 = rsp_vld_0 ? rd_dat_0 : 72'd0;
  assign rsp_dat_1 = rsp_vld_1 ? rd_dat_1 : 72'd0;
`endif

endmodule

// File: tb/tb_ra_64x72_rd_sched.sv
// tb/tb_ra_64x72_rd_sched.sv - self-checking bench for ra_64x72_rd_sched with a 2-cycle array model
module tb_ra_64x72_rd_sched;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [3:0]   req_vld;
  logic [23:0]  req_adr;
  logic [3:0]   req_gnt;
  logic         wr_req;
  logic [5:0]   wr_adr;
  logic [71:0]  wr_dat;
  logic         wr_gnt;
  logic         init_done;
  logic         rsp_vld_0, rsp_vld_1;
  logic [1:0]   rsp_id_0, rsp_id_1;
  logic [71:0]  rsp_dat_0, rsp_dat_1;
  logic         rd_enb_0, rd_enb_1;
  logic [5:0]   rd_adr_0, rd_adr_1;
  logic [71:0]  rd_dat_0, rd_dat_1;
  logic         wr_enb_0;
  logic [5:0]   wr_adr_0;
  logic [71:0]  wr_dat_0;

  ra_64x72_rd_sched #(.RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_adr(req_adr), .req_gnt(req_gnt),
    .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_gnt(wr_gnt),
    .init_done(init_done),
    .rsp_vld_0(rsp_vld_0), .rsp_id_0(rsp_id_0), .rsp_dat_0(rsp_dat_0),
    .rsp_vld_1(rsp_vld_1), .rsp_id_1(rsp_id_1), .rsp_dat_1(rsp_dat_1),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_dat_0(rd_dat_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1), .rd_dat_1(rd_dat_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0)
  );

  // Array model: inputs latched, then data latched; never-written words read as junk.
  logic [71:0] mem [64];
  logic [63:0] mem_ok = 64'd0;
  logic        a_en0, a_en1;
  logic [5:0]  a_adr0, a_adr1;
  always @(posedge clk) begin
    if (wr_enb_0) begin
      mem[wr_adr_0]    <= wr_dat_0;
      mem_ok[wr_adr_0] <= 1'b1;
    end
    a_en0  <= rd_enb_0;
    a_en1  <= rd_enb_1;
    a_adr0 <= rd_adr_0;
    a_adr1 <= rd_adr_1;
    rd_dat_0 <= a_en0 ? (mem_ok[a_adr0] ? mem[a_adr0] : {9{8'hBD}}) : {9{8'hEE}};
    rd_dat_1 <= a_en1 ? (mem_ok[a_adr1] ? mem[a_adr1] : {9{8'hBD}}) : {9{8'hEE}};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [71:0] dat;
    logic [31:0] due;
  } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  typedef struct packed {
    logic [3:0]  vld;
    logic [23:0] adr;
    logic        wr;
    logic [5:0]  wadr;
    logic [71:0] wdat;
    logic [3:0]  gnt;
    logic        en0;
    logic [1:0]  id0;
    logic        en1;
    logic [1:0]  id1;
  } vec_t;
  localparam int NV = 10;
  vec_t tbl [NV];

  logic [71:0] exp_mem [64];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int lane, input logic [1:0] id, input logic [71:0] d);
    rsp_t e;
    e.id  = id;
    e.dat = d;
    e.due = 32'(cyc + LAT);
    if (lane == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  function automatic vec_t mk(logic [3:0] vld, logic [5:0] a0, logic [5:0] a1, logic [5:0] a2,
                              logic [5:0] a3, logic wr, logic [5:0] wadr, logic [71:0] wdat,
                              logic [3:0] gnt, logic en0, logic [1:0] id0, logic en1, logic [1:0] id1);
    vec_t v;
    v.vld = vld; v.adr = {a3, a2, a1, a0};
    v.wr = wr; v.wadr = wadr; v.wdat = wdat;
    v.gnt = gnt; v.en0 = en0; v.id0 = id0; v.en1 = en1; v.id1 = id1;
    return v;
  endfunction

  // Response scoreboard: compares id, data and arrival cycle; also flags missing and spurious responses.
  initial forever begin
    rsp_t e;
    @(negedge clk);
    #2;
    if (rsp_vld_0) begin
      if (q0.size() == 0) chk("rsp0_spurious", 128'(rsp_vld_0), 128'd0);
      else begin
        e = q0.pop_front();
        chk("rsp0", {16'(cyc), rsp_id_0, rsp_dat_0}, {e.due[15:0], e.id, e.dat});
      end
    end else begin
      chk("rsp0_dat_idle", 128'(rsp_dat_0), 128'd0);
      if (q0.size() > 0 && q0[0].due <= 32'(cyc)) begin
        chk("rsp0_missing", 128'(rsp_vld_0), 128'd1);
        e = q0.pop_front();
      end
    end
    if (rsp_vld_1) begin
      if (q1.size() == 0) chk("rsp1_spurious", 128'(rsp_vld_1), 128'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1", {16'(cyc), rsp_id_1, rsp_dat_1}, {e.due[15:0], e.id, e.dat});
      end
    end else begin
      chk("rsp1_dat_idle", 128'(rsp_dat_1), 128'd0);
      if (q1.size() > 0 && q1[0].due <= 32'(cyc)) begin
        chk("rsp1_missing", 128'(rsp_vld_1), 128'd1);
        e = q1.pop_front();
      end
    end
  end

  task automatic run_init(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = 1'b0; req_vld = 4'hF; req_adr = 24'hFFFFFF;
      wr_req = 1'b1; wr_adr = 6'h3F; wr_dat = '1;
      #1;
      chk("init_fill", {wr_enb_0, wr_adr_0, wr_dat_0, init_done, req_gnt, wr_gnt, rd_enb_0, rd_enb_1},
          {1'b1, 6'(k), 72'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic post_init();
    @(negedge clk);
    req_vld = 4'd0; wr_req = 1'b0; wr_adr = 6'd0; wr_dat = 72'd0;
    #1;
    chk("init_done", {init_done, wr_enb_0, req_gnt}, {1'b1, 1'b0, 4'd0});
    for (int i = 0; i < 64; i++) exp_mem[i] = 72'd0;
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    req_vld = 4'd0; wr_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    chk(nm, 128'(q0.size() + q1.size()), 128'd0);
  endtask

  initial begin
    int g;
    logic [1:0] id0;
    logic [5:0] a0, a1;
    tbl[0] = mk(4'b0000,  0,  0,  0,  0, 1'b1,  5, {9{8'hA5}}, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
    tbl[1] = mk(4'b0100,  0,  0,  5,  0, 1'b0,  0, 72'd0,      4'b0100, 1'b1, 2'd2, 1'b0, 2'd0);
    tbl[2] = mk(4'b1001, 10,  0,  0, 13, 1'b1, 20, 72'h20_0123_4567_89AB_CDEF, 4'b1001, 1'b1, 2'd3, 1'b1, 2'd0);
    tbl[3] = mk(4'b0011, 11, 12,  0,  0, 1'b1, 21, 72'h21_FEDC_BA98_7654_3210, 4'b0011, 1'b1, 2'd1, 1'b1, 2'd0);
    tbl[4] = mk(4'b1000,  0,  0,  0, 14, 1'b1, 22, 72'h22_5A5A_5A5A_5A5A_5A5A, 4'b1000, 1'b1, 2'd3, 1'b0, 2'd0);
    tbl[5] = mk(4'b1111, 20, 21, 22, 23, 1'b1, 23, 72'h23_C3C3_C3C3_C3C3_C3C3, 4'b0011, 1'b1, 2'd0, 1'b1, 2'd1);
    tbl[6] = mk(4'b1111, 20, 21, 22, 23, 1'b0,  0, 72'd0,      4'b1100, 1'b1, 2'd2, 1'b1, 2'd3);
    tbl[7] = mk(4'b1111, 20, 21, 22, 23, 1'b0,  0, 72'd0,      4'b0011, 1'b1, 2'd0, 1'b1, 2'd1);
    tbl[8] = mk(4'b0010,  0,  5,  0,  0, 1'b1, 40, 72'h40_0F0F_0F0F_0F0F_0F0F, 4'b0010, 1'b1, 2'd1, 1'b0, 2'd0);
    tbl[9] = mk(4'b0100,  0,  0, 40,  0, 1'b0,  0, 72'd0,      4'b0100, 1'b1, 2'd2, 1'b0, 2'd0);

    reset = 1'b1; req_vld = 4'hF; req_adr = 24'd0; wr_req = 1'b1; wr_adr = 6'h3F; wr_dat = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {init_done, req_gnt, wr_gnt, rd_enb_0, rd_enb_1, rsp_vld_0, rsp_vld_1}, 128'd0);
    run_init(64);
    post_init();

    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      g = c / 2;
      req_vld = 4'hF;
      req_adr = {6'(4*g+3), 6'(4*g+2), 6'(4*((c+1)/2)+1), 6'(4*((c+1)/2))};
      #1;
      id0 = 2'((c % 2) * 2);
      chk("readall_grant", {req_gnt, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1},
          {((c % 2) != 0) ? 4'b1100 : 4'b0011, 1'b1, 6'(4*g+id0), 1'b1, 6'(4*g+id0+1)});
      push(0, id0, 72'd0);
      push(1, id0 + 2'd1, 72'd0);
    end

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      req_vld = tbl[r].vld; req_adr = tbl[r].adr;
      wr_req = tbl[r].wr; wr_adr = tbl[r].wadr; wr_dat = tbl[r].wdat;
      #1;
      a0 = tbl[r].en0 ? tbl[r].adr[6*tbl[r].id0 +: 6] : 6'd0;
      a1 = tbl[r].en1 ? tbl[r].adr[6*tbl[r].id1 +: 6] : 6'd0;
      chk($sformatf("vec%0d", r),
          {req_gnt, wr_gnt, wr_enb_0, wr_adr_0, wr_dat_0, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1},
          {tbl[r].gnt, tbl[r].wr, tbl[r].wr, tbl[r].wadr, tbl[r].wdat, tbl[r].en0, a0, tbl[r].en1, a1});
      if (tbl[r].en0) push(0, tbl[r].id0, exp_mem[a0]);
      if (tbl[r].en1) push(1, tbl[r].id1, exp_mem[a1]);
      if (tbl[r].wr) exp_mem[tbl[r].wadr] = tbl[r].wdat;
    end

`ifdef RA_WR_BYPASS_EN
    @(negedge clk);
    req_vld = 4'b0001; req_adr = {18'd0, 6'd9};
    wr_req = 1'b1; wr_adr = 6'd9; wr_dat = 72'h1234;
    #1;
    chk("bypass_issue", {req_gnt, rd_enb_0, rd_adr_0, wr_enb_0}, {4'b0001, 1'b1, 6'd9, 1'b1});
    push(0, 2'd0, 72'h1234);
    exp_mem[9] = 72'h1234;
`endif
    drain("table_drain");

    @(negedge clk);
    req_vld = 4'b0011; req_adr = {12'd0, 6'd31, 6'd30};
    #1;
    chk("inflight_issue", {rd_enb_0, rd_enb_1}, 2'b11);
    @(negedge clk);
    req_vld = 4'd0; reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("reset_gates", {req_gnt, rd_enb_0, rd_enb_1, wr_enb_0, rsp_vld_0, rsp_vld_1}, 128'd0);
    run_init(20);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_midfill", {wr_enb_0, req_gnt, wr_gnt}, 128'd0);
    run_init(64);
    post_init();

    @(negedge clk);
    req_vld = 4'b1100; req_adr = {6'd40, 6'd5, 12'd0};
    #1;
    chk("post_reset_read", {req_gnt, rd_adr_0, rd_adr_1}, {4'b1100, 6'd5, 6'd40});
    push(0, 2'd2, 72'd0);
    push(1, 2'd3, 72'd0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
